// File: rtl/uart_rx_if.sv
// Word-side bundle of the UART receiver: serial line, bit-rate divider and the
// valid/ready handshake with its error flags.
interface uart_rx_if #(parameter int DATA_WIDTH = 8);
  logic                  rx;
  logic [15:0]           baud_div;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  parity_err;
  logic                  frame_err;
  logic                  overrun_err;
  logic                  busy;

  modport master (
    output rx, baud_div, rx_ready,
    input  rx_data, rx_valid, parity_err, frame_err, overrun_err, busy
  );

  modport slave (
    input  rx, baud_div, rx_ready,
    output rx_data, rx_valid, parity_err, frame_err, overrun_err, busy
  );
endinterface

// File: rtl/uart_rx_core.sv
// UART receiver: synchronises rx, samples each bit at its oversampled midpoint,
// checks parity/stop bits and presents each word on a valid/ready handshake.
//
// state   | meaning
// IDLE    | line idle, waiting for a low level
// START   | start bit seen, confirm it is still low at its midpoint
// DATA    | shifting in data bits, LSB first
// PARITY  | sampling the parity bit
// STOP    | sampling STOP_BITS stop bits
// DELIVER | one cycle: hand the word over or flag an overrun
// BREAK   | line held low after a frame, wait for it to go high
module uart_rx_core #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input logic      clk,
  input logic      reset,
  uart_rx_if.slave bus
);
  localparam int              SW        = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0]   SMP_MID   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0]   SMP_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [2:0]      DATA_LAST = 3'(DATA_WIDTH - 1);
  localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic            PODD      = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DELIVER, BREAK} state_t;

  state_t                state;
  logic                  sync1, rxs;
  logic [15:0]           div_lim, tick_cnt;
  logic [SW-1:0]         smp_cnt;
  logic [2:0]            bit_idx;
  logic [DATA_WIDTH-1:0] shreg, data_q;
  logic                  par_acc, parity_err_n, frame_err_n;
  logic                  valid_q, perr_q, ferr_q, ovr_q, busy_q;
  logic                  tick, mid;

  assign tick = (tick_cnt == div_lim);
  assign mid  = tick && (smp_cnt == SMP_MID);

  assign bus.rx_data     = data_q;
  assign bus.rx_valid    = valid_q;
  assign bus.parity_err  = perr_q;
  assign bus.frame_err   = ferr_q;
  assign bus.overrun_err = ovr_q;
  assign bus.busy        = busy_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= bus.rx;
      rxs   <= sync1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      div_lim      <= '0;
      tick_cnt     <= '0;
      smp_cnt      <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      par_acc      <= 1'b0;
      parity_err_n <= 1'b0;
      frame_err_n  <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      ovr_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (valid_q && bus.rx_ready) valid_q <= 1'b0;

      if (state != IDLE) begin
        if (tick) begin
          tick_cnt <= '0;
          smp_cnt  <= (smp_cnt == SMP_LAST) ? '0 : smp_cnt + 1'b1;
        end else begin
          tick_cnt <= tick_cnt + 16'd1;
        end
      end

      case (state)
        IDLE: begin
          div_lim  <= (bus.baud_div == 16'd0) ? 16'd0 : bus.baud_div - 16'd1;
          tick_cnt <= '0;
          smp_cnt  <= '0;
          if (!rxs) begin
            state        <= START;
            busy_q       <= 1'b1;
            par_acc      <= 1'b0;
            parity_err_n <= 1'b0;
            frame_err_n  <= 1'b0;
          end
        end
        START: if (mid) begin
          if (rxs) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            state   <= DATA;
            bit_idx <= '0;
          end
        end
        DATA: if (mid) begin
          shreg   <= {rxs, shreg[DATA_WIDTH-1:1]};
          par_acc <= par_acc ^ rxs;
          if (bit_idx == DATA_LAST) begin
            bit_idx <= '0;
            state   <= (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_idx <= bit_idx + 3'd1;
          end
        end
        PARITY: if (mid) begin
          parity_err_n <= par_acc ^ rxs ^ PODD;
          state        <= STOP;
        end
        STOP: if (mid) begin
          if (!rxs) frame_err_n <= 1'b1;
          if (bit_idx == STOP_LAST) state <= DELIVER;
          else bit_idx <= bit_idx + 3'd1;
        end
        DELIVER: begin
          // a word still waiting without acceptance wins; the new one is dropped
          if (!valid_q || bus.rx_ready) begin
            data_q  <= shreg;
            perr_q  <= parity_err_n;
            ferr_q  <= frame_err_n;
            valid_q <= 1'b1;
          end else begin
            ovr_q <= 1'b1;
          end
          state  <= rxs ? IDLE : BREAK;
          busy_q <= ~rxs;
        end
        BREAK: if (rxs) begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: an 8N1/16x receiver and an 8E2/8x receiver, checked
// every cycle against a frame-timing model plus directed literal expectations.
module tb_uart_rx_core;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        rx_drv   [2];
  logic        ready_drv[2];
  logic [15:0] baud_drv [2];
  logic        dv[2], dbusy[2], dovr[2], dpe[2], dfe[2];
  logic [7:0]  dd[2];

  uart_rx_if #(.DATA_WIDTH(8)) u0 ();
  uart_rx_if #(.DATA_WIDTH(8)) u1 ();

  assign u0.rx = rx_drv[0];  assign u0.rx_ready = ready_drv[0];  assign u0.baud_div = baud_drv[0];
  assign u1.rx = rx_drv[1];  assign u1.rx_ready = ready_drv[1];  assign u1.baud_div = baud_drv[1];
  assign dv[0] = u0.rx_valid;  assign dbusy[0] = u0.busy;  assign dovr[0] = u0.overrun_err;
  assign dpe[0] = u0.parity_err;  assign dfe[0] = u0.frame_err;  assign dd[0] = u0.rx_data;
  assign dv[1] = u1.rx_valid;  assign dbusy[1] = u1.busy;  assign dovr[1] = u1.overrun_err;
  assign dpe[1] = u1.parity_err;  assign dfe[1] = u1.frame_err;  assign dd[1] = u1.rx_data;

  uart_rx_core #(.DATA_WIDTH(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    u_dut0 (.clk(clk), .reset(reset), .bus(u0));
  uart_rx_core #(.DATA_WIDTH(8), .OVERSAMPLE(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2))
    u_dut1 (.clk(clk), .reset(reset), .bus(u1));

  function automatic int os_of(int k);  return (k == 0) ? 16 : 8; endfunction
  function automatic int pen_of(int k); return (k == 0) ? 0 : 1;  endfunction
  function automatic int sb_of(int k);  return (k == 0) ? 1 : 2;  endfunction
  function automatic logic podd_of(int k); return 1'b0; endfunction

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s[%0d] @%0t: got %0h, expected %0h", nm, k, $time, act, exp);
    end
  endtask

  // Frame-timing model: a frame is detected on the edge where the twice-delayed
  // line is first seen low; bit i is sampled (OS/2)*D + i*OS*D edges later.
  int         cyc = 0;
  int         m_mode[2];            // 0 idle, 1 in frame (incl. deliver), 2 waiting for high
  int         m_e[2], m_D[2], m_del[2];
  logic [7:0] m_sh[2];
  logic       m_pb[2], m_fe[2];
  logic       m_valid[2], m_ovr[2], m_pe_o[2], m_fe_o[2];
  logic [7:0] m_data[2];
  logic       l1[2], l2[2];

  task automatic model_step(input int k);
    int B, n, idx, last;
    logic line;
    line  = l2[k];
    l2[k] = l1[k];
    l1[k] = rx_drv[k];
    m_ovr[k] = 1'b0;
    if (m_mode[k] == 1 && cyc == m_del[k]) begin
      if (!m_valid[k] || ready_drv[k]) begin
        m_valid[k] = 1'b1;
        m_data[k]  = m_sh[k];
        m_pe_o[k]  = (pen_of(k) != 0) ? (((^m_sh[k]) ^ m_pb[k]) != podd_of(k)) : 1'b0;
        m_fe_o[k]  = m_fe[k];
      end else begin
        m_ovr[k] = 1'b1;
      end
      m_mode[k] = line ? 0 : 2;
    end else begin
      if (m_valid[k] && ready_drv[k]) m_valid[k] = 1'b0;
      case (m_mode[k])
        0: if (!line) begin
          m_mode[k] = 1;
          m_e[k]    = cyc;
          m_D[k]    = (baud_drv[k] == 16'd0) ? 1 : int'(baud_drv[k]);
          m_fe[k]   = 1'b0;
          m_pb[k]   = 1'b0;
          m_del[k]  = -1;
        end
        2: if (line) m_mode[k] = 0;
        default: begin
          B    = os_of(k) * m_D[k];
          n    = cyc - m_e[k] - (os_of(k) / 2) * m_D[k];
          last = 8 + pen_of(k) + sb_of(k);
          if (n >= 0 && n % B == 0) begin
            idx = n / B;
            if (idx == 0) begin
              if (line) m_mode[k] = 0;
            end else if (idx <= 8) begin
              m_sh[k][idx-1] = line;
            end else if (pen_of(k) != 0 && idx == 9) begin
              m_pb[k] = line;
            end else begin
              if (!line) m_fe[k] = 1'b1;
              if (idx == last) m_del[k] = cyc + 1;
            end
          end
        end
      endcase
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_mode[k] = 0; m_valid[k] = 1'b0; m_ovr[k] = 1'b0; m_pe_o[k] = 1'b0; m_fe_o[k] = 1'b0;
        m_data[k] = 8'h00; m_del[k] = -1; l1[k] = 1'b1; l2[k] = 1'b1;
      end else begin
        model_step(k);
      end
    end
  end

  int         rise_cyc[2], rise_cnt[2], ovr_cnt[2];
  logic [7:0] rise_data[2];
  logic       rise_pe[2], rise_fe[2], pv[2];

  initial for (int k = 0; k < 2; k++) begin
    rise_cyc[k] = 0; rise_cnt[k] = 0; ovr_cnt[k] = 0; pv[k] = 1'b0;
    rise_data[k] = 8'h00; rise_pe[k] = 1'b0; rise_fe[k] = 1'b0;
  end

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rx_valid", k, 32'(dv[k]), 32'(m_valid[k]));
      chk("busy", k, 32'(dbusy[k]), 32'(m_mode[k] != 0));
      chk("overrun_err", k, 32'(dovr[k]), 32'(m_ovr[k]));
      if (m_valid[k]) begin
        chk("rx_data", k, 32'(dd[k]), 32'(m_data[k]));
        chk("parity_err", k, 32'(dpe[k]), 32'(m_pe_o[k]));
        chk("frame_err", k, 32'(dfe[k]), 32'(m_fe_o[k]));
      end
      if (dv[k] && !pv[k]) begin
        rise_cyc[k] = cyc; rise_cnt[k]++;
        rise_data[k] = dd[k]; rise_pe[k] = dpe[k]; rise_fe[k] = dfe[k];
      end
      pv[k] = dv[k];
      if (dovr[k]) ovr_cnt[k]++;
    end
  end

  task automatic drive(input int k, input logic v, input int n);
    rx_drv[k] = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input int k, input logic [7:0] d, input logic pb, input logic stp);
    int B;
    B = os_of(k) * ((baud_drv[k] == 16'd0) ? 1 : int'(baud_drv[k]));
    drive(k, 1'b0, B);
    for (int i = 0; i < 8; i++) drive(k, d[i], B);
    if (pen_of(k) != 0) drive(k, pb, B);
    drive(k, stp, B * sb_of(k));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached before the bench completed");
    $fatal(1, "watchdog");
  end

  logic done[2];
  int c0, r0, o0;

  initial begin
    for (int k = 0; k < 2; k++) begin
      rx_drv[k] = 1'b1; ready_drv[k] = 1'b1; baud_drv[k] = 16'd1; done[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // basic 8N1 receive with fixed latency from the first capturing edge
    c0 = cyc; r0 = rise_cnt[0];
    send(0, 8'hA5, 1'b0, 1'b1);
    drive(0, 1'b1, 30);
    chk("lat_rise_edge", 0, 32'(rise_cyc[0]), 32'(c0 + 156));
    chk("basic_count", 0, 32'(rise_cnt[0] - r0), 32'd1);
    chk("basic_data", 0, 32'(rise_data[0]), 32'hA5);
    chk("basic_perr", 0, 32'(rise_pe[0]), 32'd0);
    chk("basic_ferr", 0, 32'(rise_fe[0]), 32'd0);

    // reset mid-frame with a word pending
    ready_drv[0] = 1'b0;
    send(0, 8'h3F, 1'b0, 1'b1);
    drive(0, 1'b1, 20);
    chk("pending_valid", 0, 32'(dv[0]), 32'd1);
    drive(0, 1'b0, 50);
    reset = 1'b1;
    #1;
    chk("rst_valid", 0, 32'(dv[0]), 32'd0);
    chk("rst_data", 0, 32'(dd[0]), 32'd0);
    chk("rst_busy", 0, 32'(dbusy[0]), 32'd0);
    chk("rst_flags", 0, {29'd0, dpe[0], dfe[0], dovr[0]}, 32'd0);
    repeat (3) @(negedge clk);
    rx_drv[0] = 1'b1;
    reset = 1'b0;
    ready_drv[0] = 1'b1;
    r0 = rise_cnt[0];
    repeat (20) @(negedge clk);
    chk("post_rst_idle", 0, 32'(dbusy[0]), 32'd0);
    chk("post_rst_novalid", 0, 32'(rise_cnt[0] - r0), 32'd0);

    // bad stop bit followed by a long break
    r0 = rise_cnt[0];
    send(0, 8'h3C, 1'b0, 1'b0);
    drive(0, 1'b0, 40 * 16);
    chk("break_count", 0, 32'(rise_cnt[0] - r0), 32'd1);
    chk("break_data", 0, 32'(rise_data[0]), 32'h3C);
    chk("break_ferr", 0, 32'(rise_fe[0]), 32'd1);
    drive(0, 1'b1, 40);
    send(0, 8'h81, 1'b0, 1'b1);
    drive(0, 1'b1, 30);
    chk("after_break_count", 0, 32'(rise_cnt[0] - r0), 32'd2);
    chk("after_break_data", 0, 32'(rise_data[0]), 32'h81);

    // overrun: two words without acceptance
    ready_drv[0] = 1'b0;
    r0 = rise_cnt[0]; o0 = ovr_cnt[0];
    send(0, 8'h11, 1'b0, 1'b1);
    send(0, 8'h22, 1'b0, 1'b1);
    drive(0, 1'b1, 30);
    chk("ovr_pulses", 0, 32'(ovr_cnt[0] - o0), 32'd1);
    chk("ovr_held_valid", 0, 32'(dv[0]), 32'd1);
    chk("ovr_held_data", 0, 32'(dd[0]), 32'h11);
    ready_drv[0] = 1'b1;
    @(negedge clk);
    ready_drv[0] = 1'b0;
    repeat (5) @(negedge clk);
    chk("ovr_accepted", 0, 32'(dv[0]), 32'd0);
    chk("ovr_one_word", 0, 32'(rise_cnt[0] - r0), 32'd1);
    ready_drv[0] = 1'b1;

    // glitch shorter than half a bit at baud_div=3, then a real frame
    baud_drv[0] = 16'd3;
    r0 = rise_cnt[0];
    drive(0, 1'b0, 12);
    drive(0, 1'b1, 100);
    chk("glitch_novalid", 0, 32'(rise_cnt[0] - r0), 32'd0);
    chk("glitch_idle", 0, 32'(dbusy[0]), 32'd0);
    send(0, 8'h5A, 1'b0, 1'b1);
    drive(0, 1'b1, 60);
    chk("div3_data", 0, 32'(rise_data[0]), 32'h5A);
    chk("div3_count", 0, 32'(rise_cnt[0] - r0), 32'd1);

    // even parity on the 8E2 receiver
    send(1, 8'h07, 1'b0, 1'b1);
    drive(1, 1'b1, 20);
    chk("par_bad_perr", 1, 32'(rise_pe[1]), 32'd1);
    chk("par_bad_data", 1, 32'(rise_data[1]), 32'h07);
    send(1, 8'h07, 1'b1, 1'b1);
    drive(1, 1'b1, 20);
    chk("par_good_perr", 1, 32'(rise_pe[1]), 32'd0);
    chk("par_good_data", 1, 32'(rise_data[1]), 32'h07);

    // randomized traffic on both receivers with a random consumer
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          logic [7:0] d;
          d = 8'($urandom);
          baud_drv[0] = 16'($urandom_range(0, 3));
          send(0, d, 1'b0, ($urandom_range(0, 7) != 0));
          drive(0, 1'b1, $urandom_range(2, 20));
        end
        done[0] = 1'b1;
      end
      begin
        for (int i = 0; i < 20; i++) begin
          logic [7:0] d;
          logic pb;
          d  = 8'($urandom);
          pb = (^d) ^ podd_of(1) ^ ($urandom_range(0, 3) == 0);
          send(1, d, pb, ($urandom_range(0, 7) != 0));
          drive(1, 1'b1, $urandom_range(2, 20));
        end
        done[1] = 1'b1;
      end
      begin
        while (!(done[0] && done[1])) begin
          ready_drv[0] = ($urandom_range(0, 3) != 0);
          ready_drv[1] = ($urandom_range(0, 3) == 0);
          @(negedge clk);
        end
      end
    join
    ready_drv[0] = 1'b1;
    ready_drv[1] = 1'b1;
    repeat (50) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
